// File: rtl/out_addr_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// out_addr_seq
//
// Output address sequencer for the kernel datapath. Every completed kernel
// window (k_fin pulse) schedules one "sweep". A sweep emits od channel write
// addresses oa = ct*os + wi (ct = 0..od-1, wi = current window index) under a
// valid/ready handshake. Up to PEND sweeps (active + queued) are tracked.
// When the queue is full, a further k_fin is dropped and the sticky ovf flag
// is set.
//
// Optional feature (compile-time macro OUT_SEQ_LAST_EN):
//   defined   -> extra output out_last marks the final beat of a frame
//                (ct == od-1 and wi == os-1).
//   undefined -> port and frame-end logic are absent.
//
// Parameters
//   CW   channel-count width (od)
//   SW   spatial-size width (os, wi)
//   AW   output address width
//   PEND max outstanding sweeps, 1..7
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   s_init   in   frame start: window index back to 0, clears ovf
//   k_fin    in   one window complete (ignored while od == 0)
//   od       in   channels per sweep, static while running
//   os       in   windows per frame, static while running (0 acts as 1)
//   o_ready  in   output buffer accepts the presented address
//   outr     out  oa valid
//   oa       out  output address
//   update   out  one-cycle pulse in the first outr cycle of each sweep
//   out_busy out  queue full
//   ovf      out  sticky: a k_fin was dropped while the queue was full
//   out_last out  (OUT_SEQ_LAST_EN only) final beat of a frame
// -----------------------------------------------------------------------------
module out_addr_seq #(
    parameter int CW   = 4,
    parameter int SW   = 10,
    parameter int AW   = 12,
    parameter int PEND = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_init,
    input  logic          k_fin,
    input  logic [CW-1:0] od,
    input  logic [SW-1:0] os,
    input  logic          o_ready,
    output logic          outr,
    output logic [AW-1:0] oa,
    output logic          update,
    output logic          out_busy,
    output logic          ovf
`ifdef OUT_SEQ_LAST_EN
    ,
    output logic          out_last
`endif
);

    localparam int QW = 3;
    localparam int PW = CW + SW;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] ct_reg, ct_next;
    logic [SW-1:0] wi_reg, wi_next;
    logic          init_pend_reg, init_pend_next;
    logic [QW-1:0] q_reg, q_next;
    logic          ovf_reg, ovf_next;
    logic          update_reg, update_next;
    logic [AW-1:0] oa_reg, oa_next;

    logic [SW-1:0] os_eff;
    logic [SW-1:0] wi_adv;
    logic [CW-1:0] od_last;
    logic          beat;
    logic          last_beat;
    logic          kf;
    logic          accept;
    logic          drop;
    logic [PW-1:0] addr_full;

    // A frame of zero windows behaves like a single window, so wi stays 0.
    assign os_eff  = (os == '0) ? SW'(1) : os;
    assign od_last = od - CW'(1);
    assign wi_adv  = (wi_reg == os_eff - SW'(1)) ? '0 : wi_reg + SW'(1);

    assign beat      = (state_reg == RUN) && o_ready;
    assign last_beat = beat && (ct_reg == od_last);
    assign kf        = k_fin && (od != '0);

    // A completing sweep frees its slot in the same cycle, so a k_fin that
    // arrives while full is still taken if the active sweep finishes now.
    assign accept = kf && ((q_reg < QW'(PEND)) || last_beat);
    assign drop   = kf && (q_reg == QW'(PEND)) && !last_beat;

    always_comb begin
        q_next = q_reg;
        case ({accept, last_beat})
            2'b10:   q_next = q_reg + QW'(1);
            2'b01:   q_next = q_reg - QW'(1);
            default: q_next = q_reg;
        endcase
    end

    // A drop in the same cycle as a frame start belongs to the new frame.
    assign ovf_next = drop || (ovf_reg && !s_init);

    always_comb begin
        state_next     = state_reg;
        ct_next        = ct_reg;
        wi_next        = wi_reg;
        init_pend_next = init_pend_reg;
        update_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_init) begin
                    wi_next = '0;
                end
                if (q_reg != '0) begin
                    state_next  = RUN;
                    ct_next     = '0;
                    update_next = 1'b1;
                end
            end
            RUN: begin
                // The running sweep keeps its window index; a frame start
                // seen mid-sweep is remembered and applied when it ends.
                if (s_init) begin
                    init_pend_next = 1'b1;
                end
                if (beat) begin
                    if (last_beat) begin
                        ct_next        = '0;
                        wi_next        = (s_init || init_pend_reg) ? '0 : wi_adv;
                        init_pend_next = 1'b0;
                        if (q_next != '0) begin
                            update_next = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        ct_next = ct_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address is registered from the next-cycle ct/wi so oa lines up with
    // the counters it describes; the full-width sum cannot overflow CW+SW.
    assign addr_full = PW'(ct_next) * PW'(os_eff) + PW'(wi_next);
    assign oa_next   = AW'(addr_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ct_reg        <= '0;
            wi_reg        <= '0;
            init_pend_reg <= 1'b0;
            q_reg         <= '0;
            ovf_reg       <= 1'b0;
            update_reg    <= 1'b0;
            oa_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            ct_reg        <= ct_next;
            wi_reg        <= wi_next;
            init_pend_reg <= init_pend_next;
            q_reg         <= q_next;
            ovf_reg       <= ovf_next;
            update_reg    <= update_next;
            oa_reg        <= oa_next;
        end
    end

    assign outr     = (state_reg == RUN);
    assign oa       = oa_reg;
    assign update   = update_reg;
    assign out_busy = (q_reg == QW'(PEND));
    assign ovf      = ovf_reg;

`ifdef OUT_SEQ_LAST_EN
    logic out_last_reg;
    logic out_last_next;

    assign out_last_next = (state_next == RUN) && (ct_next == od_last) &&
                           (wi_next == os_eff - SW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last_reg <= 1'b0;
        end else begin
            out_last_reg <= out_last_next;
        end
    end

    assign out_last = out_last_reg;
`endif

endmodule

// File: tb/tb_out_addr_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_out_addr_seq
//
// Directed scenarios followed by randomized traffic. A behavioural model
// tracks outstanding sweeps as a count, the window index of the next sweep
// and the beat position within the active sweep, and predicts outr, oa,
// update, out_busy and ovf every cycle.
// -----------------------------------------------------------------------------
module tb_out_addr_seq;

    localparam int CW   = 4;
    localparam int SW   = 10;
    localparam int AW   = 12;
    localparam int PEND = 2;

    logic          clk;
    logic          rst_n;
    logic          s_init;
    logic          k_fin;
    logic [CW-1:0] od;
    logic [SW-1:0] os;
    logic          o_ready;
    logic          outr;
    logic [AW-1:0] oa;
    logic          update;
    logic          out_busy;
    logic          ovf;
`ifdef OUT_SEQ_LAST_EN
    logic          out_last;
`endif

    out_addr_seq #(.CW(CW), .SW(SW), .AW(AW), .PEND(PEND)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_init   (s_init),
        .k_fin    (k_fin),
        .od       (od),
        .os       (os),
        .o_ready  (o_ready),
        .outr     (outr),
        .oa       (oa),
        .update   (update),
        .out_busy (out_busy),
        .ovf      (ovf)
`ifdef OUT_SEQ_LAST_EN
        ,
        .out_last (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    int q_m      = 0;   // outstanding sweeps incl. active
    int ovf_m    = 0;
    int frame_wi = 0;   // window index the next sweep will use
    int cur_wi   = 0;   // window index of the active sweep
    int bidx     = 0;   // beat index inside the active sweep
    int fresh    = 1;   // next outr cycle is the first of a sweep
    int exp_outr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // return just after the next rising edge so the caller can drive inputs.
    task automatic step();
        int os_e, odv, kf, acc, drop, last, prev_q, exp_last;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_outr", outr, 0);
            chk("rst_update", update, 0);
            chk("rst_oa", oa, 0);
            chk("rst_busy", out_busy, 0);
            chk("rst_ovf", ovf, 0);
`ifdef OUT_SEQ_LAST_EN
            chk("rst_last", out_last, 0);
`endif
            q_m = 0; ovf_m = 0; frame_wi = 0; cur_wi = 0;
            bidx = 0; fresh = 1; exp_outr = 0;
        end else begin
            os_e = (os == 0) ? 1 : int'(os);
            odv  = int'(od);
            chk("outr", outr, exp_outr);
            chk("busy", out_busy, (q_m == PEND) ? 1 : 0);
            chk("ovf", ovf, ovf_m);
            last = 0;
            exp_last = 0;
            if (outr) begin
                if (fresh != 0) begin
                    cur_wi   = frame_wi;
                    frame_wi = (cur_wi + 1 == os_e) ? 0 : cur_wi + 1;
                    bidx     = 0;
                end
                chk("update", update, fresh);
                chk("oa", oa, (bidx * os_e + cur_wi) % (1 << AW));
                exp_last = (bidx == odv - 1 && cur_wi == os_e - 1) ? 1 : 0;
                fresh = 0;
                if (o_ready) begin
                    if (bidx == odv - 1) begin
                        last  = 1;
                        fresh = 1;
                    end else begin
                        bidx++;
                    end
                end
            end else begin
                chk("update_idle", update, 0);
            end
`ifdef OUT_SEQ_LAST_EN
            chk("out_last", out_last, exp_last);
`endif
            if (s_init) frame_wi = 0;
            kf     = (k_fin && odv != 0) ? 1 : 0;
            acc    = (kf != 0 && (q_m < PEND || last != 0)) ? 1 : 0;
            drop   = (kf != 0 && q_m == PEND && last == 0) ? 1 : 0;
            prev_q = q_m;
            q_m    = q_m + acc - last;
            ovf_m  = (drop != 0 || (ovf_m != 0 && !s_init)) ? 1 : 0;
            exp_outr = outr ? ((q_m > 0) ? 1 : 0) : ((prev_q > 0) ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_kfin();
        k_fin = 1'b1;
        step();
        k_fin = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        k_fin   = 1'b0;
        s_init  = 1'b0;
        o_ready = 1'b1;
        while ((q_m != 0 || exp_outr != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_q", q_m, 0);
        step();
        chk("drain_outr", outr, 0);
    endtask

    task automatic configure(input int d, input int s);
        od     = CW'(d);
        os     = SW'(s);
        s_init = 1'b1;
        step();
        s_init = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_init  = 1'b0;
        k_fin   = 1'b0;
        od      = 4'd3;
        os      = 10'd4;
        o_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 1: single sweep, od=3 os=4, addresses 0,4,8
        pulse_kfin();
        idle(8);

        // 2: four sweeps 10 cycles apart, then a fifth that wraps wi
        configure(3, 4);
        for (int i = 0; i < 5; i++) begin
            pulse_kfin();
            idle(9);
        end
        drain();

        // 3: stalled output, three back-to-back k_fin -> full and overflow
        o_ready = 1'b0;
        k_fin = 1'b1;
        idle(3);
        k_fin = 1'b0;
        idle(3);
        chk("busy_full", out_busy, 1);
        chk("ovf_set", ovf, 1);
        s_init = 1'b1;
        step();
        s_init = 1'b0;
        step();
        chk("ovf_cleared", ovf, 0);
        drain();

        // 4: o_ready toggling 1010 across a sweep
        configure(3, 4);
        pulse_kfin();
        for (int i = 0; i < 14; i++) begin
            o_ready = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        drain();

        // 5: asynchronous reset with ct=1, then restart at oa 0
        configure(3, 4);
        pulse_kfin();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        pulse_kfin();
        drain();

        // od=0 ignores k_fin
        configure(0, 4);
        pulse_kfin();
        idle(4);
        chk("od0_q", q_m, 0);

`ifdef OUT_SEQ_LAST_EN
        // 6: frame-end marker, od=2 os=2
        configure(2, 2);
        pulse_kfin();
        pulse_kfin();
        drain();
`endif

        // randomized traffic, reconfigured between rounds
        for (int r = 0; r < 8; r++) begin
            drain();
            configure(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
            for (int c = 0; c < 150; c++) begin
                k_fin   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                o_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
                s_init  = ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0;
                step();
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
